// File: rtl/ft_recovery_ctrl.sv
// ---------------------------------------------------------------------------
// ft_recovery_ctrl
//
// Lockstep fault-tolerance recovery controller. Compares the register-file
// write ports of two lockstepped cores. On a divergence it resets the cores
// for a fixed number of cycles and then waits for a software recovery
// routine to report completion. Each recovery attempt is bounded by a
// timeout. After MAX_RETRIES timed-out attempts the controller parks in HALT
// with reset and a major alert asserted until the next rst_i.
//
// Parameters
//   RESET_CYCLES   cycles reset_o is held per recovery attempt (1..255)
//   TIMEOUT_CYCLES RECOVER cycles without done_i before giving up (2..65535)
//   MAX_RETRIES    timed-out attempts allowed before HALT (1..15)
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   enable_i                lockstep comparison enable
//   we_/addr_/data_{a,b}_i  register-file write ports of core 0 / core 1
//   pc_i                    core 0 program counter
//   valid_instr_exec_i      an instruction is retiring in ID/EX
//   done_i                  recovery routine finished
//   reset_o                 core reset (RESET and HALT)
//   recover_o               one-cycle pulse on each RECOVER entry
//   recovering_o            high throughout RECOVER
//   alert_major_o           unrecoverable fault (HALT)
//   checkpoint_pc_o         last PC retired with no mismatch
//   err_count_o             saturating mismatch count
// ---------------------------------------------------------------------------
module ft_recovery_ctrl #(
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRIES    = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        we_a_i,
  input  logic        we_b_i,
  input  logic [4:0]  addr_a_i,
  input  logic [4:0]  addr_b_i,
  input  logic [31:0] data_a_i,
  input  logic [31:0] data_b_i,
  input  logic [31:0] pc_i,
  input  logic        valid_instr_exec_i,
  input  logic        done_i,
  output logic        reset_o,
  output logic        recover_o,
  output logic        recovering_o,
  output logic        alert_major_o,
  output logic [31:0] checkpoint_pc_o,
  output logic [7:0]  err_count_o
);

  localparam int DATA_W = 32;

  localparam logic [7:0]  RST_LAST  = 8'(RESET_CYCLES - 1);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    RESET   = 2'd1,
    RECOVER = 2'd2,
    HALT    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          rst_cnt_q, rst_cnt_d;
  logic [15:0]         to_cnt_q, to_cnt_d;
  logic [3:0]          retry_q, retry_d;
  logic [7:0]          err_q, err_d;
  logic [DATA_W-1:0]   ckpt_q, ckpt_d;
  logic                mismatch;
  logic [3:0]          retry_inc;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A write on only one core, or writes to different registers/values.
  assign mismatch = enable_i &
                    ((we_a_i != we_b_i) |
                     (we_a_i & we_b_i & ((addr_a_i != addr_b_i) |
                                         (data_a_i != data_b_i))));

  assign retry_inc = retry_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    to_cnt_d  = to_cnt_q;
    retry_d   = retry_q;
    err_d     = err_q;
    ckpt_d    = ckpt_q;
    case (state_q)
      MONITOR: begin
        if (mismatch) begin
          state_d   = RESET;
          rst_cnt_d = '0;
          retry_d   = '0;
          err_d     = sat_inc8(err_q);
        end else if (valid_instr_exec_i) begin
          ckpt_d = pc_i;
        end
      end
      RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d  = RECOVER;
          // to_cnt == 0 marks the first RECOVER cycle (drives recover_o).
          to_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 8'd1;
        end
      end
      RECOVER: begin
        // done_i wins over a timeout expiring in the same cycle.
        if (done_i) begin
          state_d = MONITOR;
        end else if (to_cnt_q == TO_LAST) begin
          retry_d = retry_inc;
          if (retry_inc == RETRY_MAX) begin
            state_d = HALT;
          end else begin
            state_d   = RESET;
            rst_cnt_d = '0;
          end
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = MONITOR;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= MONITOR;
      rst_cnt_q <= '0;
      to_cnt_q  <= '0;
      retry_q   <= '0;
      err_q     <= '0;
      ckpt_q    <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      to_cnt_q  <= to_cnt_d;
      retry_q   <= retry_d;
      err_q     <= err_d;
      ckpt_q    <= ckpt_d;
    end
  end

  // Outputs decode registered state only.
  assign reset_o         = (state_q == RESET) || (state_q == HALT);
  assign recover_o       = (state_q == RECOVER) && (to_cnt_q == 16'd0);
  assign recovering_o    = (state_q == RECOVER);
  assign alert_major_o   = (state_q == HALT);
  assign checkpoint_pc_o = ckpt_q;
  assign err_count_o     = err_q;

endmodule

// File: doc/ft_recovery_ctrl.md
FT_RECOVERY_CTRL -- requirements
Module: ft_recovery_ctrl

Interface
- REQ-001 SHALL have parameter RESET_CYCLES, default 4: number of cycles reset_o is held per recovery attempt (legal range 1..255).
- REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: number of RECOVER cycles without done_i before the attempt is abandoned (legal range 2..65535).
- REQ-003 SHALL have parameter MAX_RETRIES, default 3: number of timed-out attempts allowed before entering HALT (legal range 1..15).
- REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-005 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
- REQ-006 SHALL have port enable_i, input, 1 bit: lockstep comparison enable.
- REQ-007 SHALL have ports we_a_i/we_b_i (input, 1 bit), addr_a_i/addr_b_i (input, 5 bits) and data_a_i/data_b_i (input, 32 bits): register-file write ports of core 0 and core 1.
- REQ-008 SHALL have ports pc_i (input, 32 bits, core 0 PC) and valid_instr_exec_i (input, 1 bit, instruction retiring in ID/EX).
- REQ-009 SHALL have port done_i, input, 1 bit: recovery routine finished.
- REQ-010 SHALL have outputs reset_o, recover_o, recovering_o and alert_major_o, each 1 bit.
- REQ-011 SHALL have outputs checkpoint_pc_o (32 bits, last PC known good) and err_count_o (8 bits, mismatch count).

Function
- REQ-012 SHALL implement FSM states MONITOR, RESET, RECOVER and HALT.
- REQ-013 SHALL define mismatch, evaluated combinationally, as enable_i & (we_a_i != we_b_i | (we_a_i & we_b_i & (addr_a_i != addr_b_i | data_a_i != data_b_i))).
- REQ-014 SHALL, in MONITOR, transition to RESET on the next edge whenever mismatch=1, increment err_count_o (saturating at 255) and clear the retry counter.
- REQ-015 SHALL, in MONITOR, load checkpoint_pc_o <= pc_i when valid_instr_exec_i=1 and mismatch=0; on a cycle with mismatch=1, checkpoint_pc_o SHALL NOT update.
- REQ-016 SHALL, in RESET, drive reset_o=1 for exactly RESET_CYCLES cycles, then transition to RECOVER.
- REQ-017 SHALL drive recover_o=1 for exactly the first cycle of each RECOVER entry (a single pulse).
- REQ-018 SHALL drive recovering_o=1 in every RECOVER cycle and 0 in all other states.
- REQ-019 SHALL, in RECOVER, transition to MONITOR on the next edge when done_i=1; done_i SHALL be ignored in every other state.
- REQ-020 SHALL, in RECOVER, count cycles and, if TIMEOUT_CYCLES elapse without done_i, increment the retry counter and re-enter RESET.
- REQ-021 SHALL transition from RECOVER to HALT instead of RESET once the retry counter reaches MAX_RETRIES.
- REQ-022 SHALL treat done_i=1 in the same cycle the timeout expires as success (MONITOR).
- REQ-023 SHALL ignore mismatch in RESET, RECOVER and HALT (no err_count_o increment, no restart).
- REQ-024 SHALL, in HALT, hold reset_o=1 and alert_major_o=1; HALT SHALL be exited only by rst_i.
- REQ-025 SHALL decode all outputs from registered state and counters only, with no combinational path from any input to any output.
- REQ-026 SHALL keep enable_i=0 from affecting RESET, RECOVER or HALT sequencing.

Reset
- REQ-027 SHALL, while rst_i=1 at a clock edge, enter MONITOR with all counters at 0, checkpoint_pc_o=0 and err_count_o=0.
- REQ-028 SHALL drive reset_o, recover_o, recovering_o and alert_major_o to 0 after reset.
- REQ-029 SHALL let rst_i asserted mid-recovery or in HALT abort immediately to the reset state on that edge.

Verification
- REQ-030 SHALL cover clean compare: both cores write x5=0x1234 with valid_instr_exec_i=1 and pc_i=0x80 -> checkpoint_pc_o=0x80, err_count_o=0, reset_o stays 0.
- REQ-031 SHALL cover data mismatch: data_a=0x1, data_b=0x3, same address, cycle N -> reset_o=1 in cycles N+1..N+4, recover_o pulse at N+5, recovering_o=1 from N+5, err_count_o=1, checkpoint_pc_o unchanged.
- REQ-032 SHALL cover recovery completion: done_i=1 in the 3rd RECOVER cycle -> recovering_o=0 on the next cycle, state MONITOR, new mismatches counted again.
- REQ-033 SHALL cover timeouts: with TIMEOUT_CYCLES=8 and done_i never asserted -> 3 RESET/RECOVER attempts, then reset_o=1 and alert_major_o=1 held until rst_i.
- REQ-034 SHALL cover we-only mismatch and disable: we_a=1, we_b=0 with enable_i=0 -> no reaction; the same with enable_i=1 -> RESET entered.
- REQ-035 SHALL cover saturation and mid-recovery reset: 256 mismatch/recover cycles -> err_count_o stays 255; rst_i in RECOVER -> all outputs 0 the next cycle.
